// File: rtl/clic_vector_fetch.sv
// Resolves the handler address for a CLIC machine external interrupt and issues one trap request per interrupt.
// Define CLIC_VECTOR_EN to enable shv vector-table fetches; without it every interrupt traps directly to mtvec.
module clic_vector_fetch #(
  parameter int vec_align = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clic_meip,
  input  logic [11:0] clic_meid,
  input  logic        clic_shv,
  input  logic        mie_enable,
  input  logic [31:0] mtvec,
  input  logic [31:0] mtvt,
  output logic        vec_valid,
  output logic [31:0] vec_addr,
  input  logic [31:0] vec_rdata,
  input  logic        vec_ready,
  output logic        trap_valid,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_cause,
  input  logic        trap_ack,
  output logic [1:0]  dbg_state
);

  // Handshakes: vec_valid/vec_addr hold until a one-cycle vec_ready pulse completes the read;
  // trap_valid/trap_pc/trap_cause hold until trap_ack is sampled high while trap_valid is high.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_REQ   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_holdoff;
  logic        r_trap_valid;
  logic [31:0] r_trap_pc;
  logic [31:0] r_trap_cause;
  logic        w_accept;
  logic        w_shv;

`ifdef CLIC_VECTOR_EN
  logic        r_vec_valid;
  logic [31:0] r_vec_addr;
  logic [31:0] w_vec_base;
  logic [31:0] w_vec_addr;
  logic        w_unused;

  assign w_shv      = clic_shv;
  assign w_vec_base = {mtvt[31:vec_align], {vec_align{1'b0}}};
  assign w_vec_addr = w_vec_base + {18'b0, clic_meid, 2'b00};
  assign vec_valid  = r_vec_valid;
  assign vec_addr   = r_vec_addr;
  assign w_unused   = &{1'b0, mtvec[1:0], vec_rdata[0], mtvt[vec_align-1:0]};
`else
  logic w_unused;

  assign w_shv     = 1'b0;
  assign vec_valid = 1'b0;
  assign vec_addr  = 32'b0;
  assign w_unused  = &{1'b0, clic_shv, mtvt, vec_rdata, vec_ready, mtvec[1:0]};
`endif

  assign trap_valid = r_trap_valid;
  assign trap_pc    = r_trap_pc;
  assign trap_cause = r_trap_cause;
  assign dbg_state  = r_state;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Holdoff keeps a stale meip from being re-taken before the core clears MIE.
        if (!r_holdoff && clic_meip && (clic_meid != 12'd0) && mie_enable) begin
          w_accept = 1'b1;
          w_next   = w_shv ? S_FETCH : S_REQ;
        end
      end
`ifdef CLIC_VECTOR_EN
      S_FETCH: begin
        if (vec_ready) w_next = S_REQ;
      end
`endif
      S_REQ: begin
        if (trap_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_holdoff    <= 1'b0;
      r_trap_valid <= 1'b0;
      r_trap_pc    <= 32'b0;
      r_trap_cause <= 32'b0;
`ifdef CLIC_VECTOR_EN
      r_vec_valid  <= 1'b0;
      r_vec_addr   <= 32'b0;
`endif
    end else begin
      r_state      <= w_next;
      r_holdoff    <= (r_state == S_REQ) && trap_ack;
      r_trap_valid <= (w_next == S_REQ);
      if (w_accept) begin
        r_trap_cause <= {1'b1, 19'b0, clic_meid};
        if (!w_shv) r_trap_pc <= {mtvec[31:2], 2'b00};
      end
`ifdef CLIC_VECTOR_EN
      r_vec_valid <= (w_next == S_FETCH);
      if (w_accept && w_shv) r_vec_addr <= w_vec_addr;
      if ((r_state == S_FETCH) && vec_ready) r_trap_pc <= {vec_rdata[31:1], 1'b0};
`endif
    end
  end

endmodule

// File: tb/tb_clic_vector_fetch.sv
// Self-checking bench for clic_vector_fetch: directed table, randomized transactions, and multi-cycle corner sequences.
module tb_clic_vector_fetch;

`ifdef CLIC_VECTOR_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        clic_meip;
  logic [11:0] clic_meid;
  logic        clic_shv;
  logic        mie_enable;
  logic [31:0] mtvec;
  logic [31:0] mtvt;
  logic        vec_valid;
  logic [31:0] vec_addr;
  logic [31:0] vec_rdata;
  logic        vec_ready;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        trap_ack;
  logic [1:0]  dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  clic_vector_fetch #(.vec_align(6)) dut (
    .clock(clock), .reset(reset),
    .clic_meip(clic_meip), .clic_meid(clic_meid), .clic_shv(clic_shv),
    .mie_enable(mie_enable), .mtvec(mtvec), .mtvt(mtvt),
    .vec_valid(vec_valid), .vec_addr(vec_addr), .vec_rdata(vec_rdata), .vec_ready(vec_ready),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_ack(trap_ack),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] meid;
    logic        shv;
    logic        mie;
    logic [31:0] mtvec;
    logic [31:0] mtvt;
    logic [31:0] rdata;
    int          rdly;
    int          adly;
    logic        exp_acc;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc_vec;
    logic [31:0] exp_pc_dir;
    logic [31:0] exp_cause;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    clic_meip  = 1'b0;
    clic_meid  = 12'd0;
    clic_shv   = 1'b0;
    mie_enable = 1'b0;
    vec_ready  = 1'b0;
    vec_rdata  = 32'b0;
    trap_ack   = 1'b0;
  endtask

  // Reference: what the interrupt should produce, computed straight from the address rules.
  function automatic vec_t model(input vec_t t);
    vec_t r;
    r = t;
    r.exp_acc    = t.mie && (t.meid != 12'd0);
    r.exp_addr   = (t.mtvt & 32'hFFFF_FFC0) + 32'(t.meid) * 32'd4;
    r.exp_pc_vec = t.rdata & 32'hFFFF_FFFE;
    r.exp_pc_dir = t.mtvec & 32'hFFFF_FFFC;
    r.exp_cause  = 32'h8000_0000 | 32'(t.meid);
    return r;
  endfunction

  task automatic run_txn(input vec_t t);
    logic        is_vec;
    logic [31:0] exp_pc;
    is_vec = VEC_EN && t.shv;
    exp_pc = is_vec ? t.exp_pc_vec : t.exp_pc_dir;
    clic_meip  = 1'b1;
    clic_meid  = t.meid;
    clic_shv   = t.shv;
    mie_enable = t.mie;
    mtvec      = t.mtvec;
    mtvt       = t.mtvt;
    step();
    if (!t.exp_acc) begin
      for (int i = 0; i < 3; i++) begin
        check("noacc_trap_valid", {31'b0, trap_valid}, 32'd0);
        check("noacc_vec_valid", {31'b0, vec_valid}, 32'd0);
        step();
      end
      idle_inputs();
      step();
      return;
    end
    // Once accepted, input changes must not disturb the interrupt.
    clic_meip  = 1'b0;
    mie_enable = 1'b0;
    clic_meid  = 12'($urandom);
    clic_shv   = ~t.shv;
    if (is_vec) begin
      check("fetch_vec_valid", {31'b0, vec_valid}, 32'd1);
      check("fetch_vec_addr", vec_addr, t.exp_addr);
      check("fetch_trap_valid", {31'b0, trap_valid}, 32'd0);
      for (int i = 0; i < t.rdly; i++) begin
        step();
        check("fetch_hold_valid", {31'b0, vec_valid}, 32'd1);
        check("fetch_hold_addr", vec_addr, t.exp_addr);
      end
      vec_ready = 1'b1;
      vec_rdata = t.rdata;
      step();
      vec_ready = 1'b0;
      vec_rdata = 32'h0BAD_0BAD;
    end
    check("req_trap_valid", {31'b0, trap_valid}, 32'd1);
    check("req_vec_valid", {31'b0, vec_valid}, 32'd0);
    check("req_trap_pc", trap_pc, exp_pc);
    check("req_trap_cause", trap_cause, t.exp_cause);
    if (!VEC_EN) check("novec_addr", vec_addr, 32'd0);
    for (int i = 0; i < t.adly; i++) begin
      step();
      check("req_hold_valid", {31'b0, trap_valid}, 32'd1);
      check("req_hold_pc", trap_pc, exp_pc);
    end
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    check("ack_trap_valid", {31'b0, trap_valid}, 32'd0);
    idle_inputs();
    step();
  endtask

  initial begin
    vec_t t;
    idle_inputs();
    mtvec = 32'b0;
    mtvt  = 32'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_vec_valid", {31'b0, vec_valid}, 32'd0);
    check("rst_vec_addr", vec_addr, 32'd0);
    check("rst_trap_valid", {31'b0, trap_valid}, 32'd0);
    check("rst_trap_pc", trap_pc, 32'd0);
    check("rst_trap_cause", trap_cause, 32'd0);

    //        meid     shv  mie  mtvec          mtvt           rdata          rdly adly acc  addr           pc_vec         pc_dir         cause
    tbl[0] = '{12'd5,   1'b0, 1'b1, 32'h8000_0103, 32'h0000_0000, 32'h0,         0, 3, 1'b1, 32'h0,         32'h8000_0100, 32'h8000_0100, 32'h8000_0005};
    tbl[1] = '{12'd3,   1'b1, 1'b1, 32'h0000_1000, 32'h0000_2040, 32'h0000_3001, 4, 1, 1'b1, 32'h0000_204C, 32'h0000_3000, 32'h0000_1000, 32'h8000_0003};
    tbl[2] = '{12'hFFF, 1'b1, 1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 0, 1'b1, 32'h0000_3FBC, 32'hDEAD_BEEE, 32'h0000_0000, 32'h8000_0FFF};
    tbl[3] = '{12'd9,   1'b0, 1'b0, 32'h0000_4000, 32'h0,         32'h0,         0, 0, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0};
    tbl[4] = '{12'd0,   1'b1, 1'b1, 32'h0000_4000, 32'h0000_1000, 32'h0,         0, 0, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0};
    tbl[5] = '{12'd1,   1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h0,         0, 2, 1'b1, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h8000_0001};
    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      t.meid  = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      t.shv   = 1'($urandom);
      t.mie   = ($urandom_range(0, 5) != 0);
      t.mtvec = $urandom;
      t.mtvt  = $urandom;
      t.rdata = $urandom;
      t.rdly  = $urandom_range(0, 4);
      t.adly  = $urandom_range(0, 3);
      run_txn(model(t));
    end

    // Gating: masked or zero-id interrupts, stray ready/ack pulses, all ignored.
    clic_meip = 1'b1; clic_meid = 12'd7; clic_shv = 1'b1; mie_enable = 1'b0; mtvt = 32'h0000_1000;
    for (int i = 0; i < 10; i++) begin
      vec_ready = 1'($urandom);
      trap_ack  = 1'($urandom);
      step();
      check("gate_mie_trap", {31'b0, trap_valid}, 32'd0);
      check("gate_mie_vec", {31'b0, vec_valid}, 32'd0);
    end
    clic_meid = 12'd0; mie_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("gate_id0_trap", {31'b0, trap_valid}, 32'd0);
      check("gate_id0_vec", {31'b0, vec_valid}, 32'd0);
    end
    idle_inputs();
    step();

    // Holdoff: ack at K with meip/mie still high; re-accept at K+2 so trap_valid returns at K+3.
    mtvec = 32'h8000_0103; clic_meip = 1'b1; clic_meid = 12'd5; clic_shv = 1'b0; mie_enable = 1'b1;
    step();
    check("hold_first_req", {31'b0, trap_valid}, 32'd1);
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    check("hold_k1_drop", {31'b0, trap_valid}, 32'd0);
    step();
    check("hold_k2_idle", {31'b0, trap_valid}, 32'd0);
    step();
    check("hold_k3_reaccept", {31'b0, trap_valid}, 32'd1);
    check("hold_k3_pc", trap_pc, 32'h8000_0100);
    idle_inputs();
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    step();

    // Reset while the vector read is outstanding; a late ready must not produce a trap.
    mtvt = 32'h0000_2040; mtvec = 32'h0000_1000;
    clic_meip = 1'b1; clic_meid = 12'd3; clic_shv = 1'b1; mie_enable = 1'b1;
    step();
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstf_vec_valid", {31'b0, vec_valid}, 32'd0);
    check("rstf_vec_addr", vec_addr, 32'd0);
    check("rstf_trap_valid", {31'b0, trap_valid}, 32'd0);
    check("rstf_trap_pc", trap_pc, 32'd0);
    check("rstf_trap_cause", trap_cause, 32'd0);
    vec_ready = 1'b1; vec_rdata = 32'h0000_3001;
    step();
    vec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstf_late_ready", {31'b0, trap_valid}, 32'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
